// File: rtl/cpu_fetch_pkg.sv
// CHIP-8 fetch stage shared definitions.
// State encodings, opcode field positions, default RAM address width.
package cpu_fetch_pkg;

   localparam int ADDR_W_DEF = 12;

   localparam int NNN_MSB = 11;
   localparam int X_MSB   = 11;
   localparam int X_LSB   = 8;
   localparam int Y_MSB   = 7;
   localparam int Y_LSB   = 4;
   localparam int KK_MSB  = 7;
   localparam int N_MSB   = 3;

   typedef enum logic [1:0] {
      S_HI    = 2'd0,
      S_LO    = 2'd1,
      S_CAP   = 2'd2,
      S_VALID = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/cpu_fetch_opcode_fields.sv
// CHIP-8 opcode field splitter.
// Pure slices of a 16-bit opcode; shared with the decoder.
module cpu_fetch_opcode_fields
   import cpu_fetch_pkg::*;
(
   input  logic [15:0] i_opcode,
   output logic [11:0] o_nnn,
   output logic [3:0]  o_x,
   output logic [3:0]  o_y,
   output logic [7:0]  o_kk,
   output logic [3:0]  o_n
);

   assign o_nnn = i_opcode[NNN_MSB:0];
   assign o_x   = i_opcode[X_MSB:X_LSB];
   assign o_y   = i_opcode[Y_MSB:Y_LSB];
   assign o_kk  = i_opcode[KK_MSB:0];
   assign o_n   = i_opcode[N_MSB:0];

endmodule

// File: rtl/cpu_fetch.sv
// CHIP-8 instruction fetch stage.
// Reads a big-endian opcode as two RAM bytes, hands it off via valid/ready.
module cpu_fetch
   import cpu_fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              flush,
   input  logic [15:0]       pc_in,
   output logic              pc_inc,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [15:0]       opcode,
   output logic [11:0]       op_nnn,
   output logic [3:0]        op_x,
   output logic [3:0]        op_y,
   output logic [7:0]        op_kk,
   output logic [3:0]        op_n,
   output logic [CNT_W-1:0]  fetch_cnt
);

   fetch_state_e     r_state;
   fetch_state_e     w_next;
   logic [7:0]       r_hi;
   logic [15:0]      r_opcode;
   logic             r_op_valid;
   logic [CNT_W-1:0] r_cnt;
   logic             w_xfer;
   logic             w_pc_inc;
   logic             w_mem_rd;
   logic             w_unused_pc;

   assign w_xfer      = r_op_valid & op_ready;
   assign w_unused_pc = ^pc_in;

   // Next state and read/increment strobes; flush overrides everything.
   always_comb begin
      w_next   = r_state;
      w_pc_inc = 1'b0;
      w_mem_rd = 1'b0;
      if (flush) begin
         w_next = S_HI;
      end else begin
         unique case (r_state)
            S_HI: begin
               if (run) begin
                  w_pc_inc = 1'b1;
                  w_mem_rd = 1'b1;
                  w_next   = S_LO;
               end
            end
            S_LO: begin
               w_pc_inc = 1'b1;
               w_mem_rd = 1'b1;
               w_next   = S_CAP;
            end
            S_CAP: begin
               w_next = S_VALID;
            end
            S_VALID: begin
               if (w_xfer) begin
                  w_next = S_HI;
               end
            end
            default: begin
               w_next = S_HI;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_HI;
      end else begin
         r_state <= w_next;
      end
   end

   // Byte capture, opcode hold and saturating transfer counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hi       <= 8'h00;
         r_opcode   <= 16'h0000;
         r_op_valid <= 1'b0;
         r_cnt      <= '0;
      end else if (flush) begin
         r_op_valid <= 1'b0;
      end else begin
         if (r_state == S_LO) begin
            r_hi <= mem_rdata;
         end
         if (r_state == S_CAP) begin
            r_opcode   <= {r_hi, mem_rdata};
            r_op_valid <= 1'b1;
         end
         if (r_state == S_VALID && w_xfer) begin
            r_op_valid <= 1'b0;
            if (r_cnt != {CNT_W{1'b1}}) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign pc_inc    = w_pc_inc;
   assign mem_rd    = w_mem_rd;
   assign mem_addr  = pc_in[ADDR_W-1:0];
   assign op_valid  = r_op_valid;
   assign opcode    = r_opcode;
   assign fetch_cnt = r_cnt;

   cpu_fetch_opcode_fields u_fields (
      .i_opcode (r_opcode),
      .o_nnn    (op_nnn),
      .o_x      (op_x),
      .o_y      (op_y),
      .o_kk     (op_kk),
      .o_n      (op_n)
   );

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: RAM and pc register file emulated here,
// opcodes predicted from RAM contents and pc arithmetic.
module tb_cpu_fetch;

   localparam int ADDR_W = 12;
   localparam int CNT_W  = 4;
   localparam int MEMSZ  = 1 << ADDR_W;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              run;
   logic              flush;
   logic [15:0]       pc_in;
   logic              pc_inc;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              op_valid;
   logic              op_ready;
   logic [15:0]       opcode;
   logic [11:0]       op_nnn;
   logic [3:0]        op_x;
   logic [3:0]        op_y;
   logic [7:0]        op_kk;
   logic [3:0]        op_n;
   logic [CNT_W-1:0]  fetch_cnt;

   logic [7:0]  ram [MEMSZ];
   logic        pc_ld;
   logic [15:0] pc_ld_val;
   int          inc_cnt;
   int          rd_cnt;
   int          total;
   int          bad;
   int          exp_cnt;

   cpu_fetch #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .flush     (flush),
      .pc_in     (pc_in),
      .pc_inc    (pc_inc),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .opcode    (opcode),
      .op_nnn    (op_nnn),
      .op_x      (op_x),
      .op_y      (op_y),
      .op_kk     (op_kk),
      .op_n      (op_n),
      .fetch_cnt (fetch_cnt)
   );

   always #5 clk = ~clk;

   // Register-file pc and 1-cycle-latency program RAM.
   always @(posedge clk) begin
      if (pc_ld) pc_in <= pc_ld_val;
      else if (pc_inc) pc_in <= pc_in + 16'd1;
      if (pc_inc) inc_cnt <= inc_cnt + 1;
      if (mem_rd) begin
         rd_cnt    <= rd_cnt + 1;
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_pc(input logic [15:0] p);
      pc_ld     = 1'b1;
      pc_ld_val = p;
      tick();
      pc_ld = 1'b0;
   endtask

   function automatic int next_cnt(input int c);
      return (c >= CMAX) ? CMAX : c + 1;
   endfunction

   // Issue a fetch at pc p, stall the handshake, then transfer.
   task automatic fetch_op(input logic [15:0] p, input int stall);
      int ai;
      int bi;
      int exp;
      int n0;
      int r0;
      int waited;
      set_pc(p);
      ai  = int'(p) % MEMSZ;
      bi  = (int'(p) + 1) % MEMSZ;
      exp = int'(ram[ai]) * 256 + int'(ram[bi]);
      n0  = inc_cnt;
      run = 1'b1;
      op_ready = 1'b0;
      #1;
      chk("issue_rd", 32'(mem_rd), 1);
      chk("issue_addr", 32'(mem_addr), ai);
      tick();
      run = 1'b0;
      #1;
      chk("lo_rd", 32'(mem_rd), 1);
      chk("lo_addr", 32'(mem_addr), bi);
      waited = 0;
      tick();
      while (!op_valid && waited < 8) begin
         tick();
         waited++;
      end
      chk("latency", waited, 1);
      chk("valid", 32'(op_valid), 1);
      chk("opcode", 32'(opcode), exp);
      chk("nnn", 32'(op_nnn), exp % 4096);
      chk("x", 32'(op_x), (exp / 256) % 16);
      chk("y", 32'(op_y), (exp / 16) % 16);
      chk("kk", 32'(op_kk), exp % 256);
      chk("n", 32'(op_n), exp % 16);
      r0 = rd_cnt;
      for (int i = 0; i < stall; i++) begin
         tick();
         chk("hold_op", 32'(opcode), exp);
         chk("hold_valid", 32'(op_valid), 1);
      end
      chk("stall_rd", rd_cnt - r0, 0);
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0;
      exp_cnt = next_cnt(exp_cnt);
      chk("xfer_valid", 32'(op_valid), 0);
      chk("fetch_cnt", 32'(fetch_cnt), exp_cnt);
      chk("pc_incs", inc_cnt - n0, 2);
   endtask

   initial begin
      int n0;
      total = 0; bad = 0; exp_cnt = 0;
      inc_cnt = 0; rd_cnt = 0;
      pc_in = 16'h0000; pc_ld = 1'b0; pc_ld_val = 16'h0000;
      mem_rdata = 8'h00;
      rst = 1'b0; run = 1'b0; flush = 1'b0; op_ready = 1'b0;
      for (int i = 0; i < MEMSZ; i++) ram[i] = 8'($urandom);
      #2;
      chk("rst_valid", 32'(op_valid), 0);
      chk("rst_opcode", 32'(opcode), 0);
      chk("rst_cnt", 32'(fetch_cnt), 0);
      chk("rst_inc", 32'(pc_inc), 0);
      chk("rst_rd", 32'(mem_rd), 0);
      chk("rst_nnn", 32'(op_nnn), 0);
      tick();
      rst = 1'b1;
      tick();

      // Directed basic fetch
      ram[12'h200] = 8'h6A;
      ram[12'h201] = 8'h42;
      fetch_op(16'h0200, 0);

      // Stalled handshake, then next fetch starts after transfer
      fetch_op(16'h0300, 5);
      set_pc(16'h0400);
      run = 1'b1;
      op_ready = 1'b0;
      #1;
      chk("restart_rd", 32'(mem_rd), 1);
      run = 1'b0;
      #1;
      chk("idle_rd", 32'(mem_rd), 0);

      // Flush in S_LO
      n0 = inc_cnt;
      run = 1'b1;
      tick();
      run = 1'b0;
      flush = 1'b1;
      #1;
      chk("flo_inc", 32'(pc_inc), 0);
      chk("flo_rd", 32'(mem_rd), 0);
      tick();
      flush = 1'b0;
      chk("flo_valid", 32'(op_valid), 0);
      chk("flo_pc", inc_cnt - n0, 1);
      chk("flo_cnt", 32'(fetch_cnt), exp_cnt);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("flo_stay", 32'(op_valid), 0);
      end
      run = 1'b1;
      #1;
      chk("flo_in_hi", 32'(mem_rd), 1);
      run = 1'b0;

      // Flush together with a transfer
      set_pc(16'h0500);
      run = 1'b1;
      tick();
      run = 1'b0;
      tick();
      tick();
      chk("fv_valid", 32'(op_valid), 1);
      flush = 1'b1;
      op_ready = 1'b1;
      tick();
      flush = 1'b0;
      op_ready = 1'b0;
      chk("fv_drop", 32'(op_valid), 0);
      chk("fv_cnt", 32'(fetch_cnt), exp_cnt);

      // Address wrap
      ram[12'hFFF] = 8'h12;
      ram[12'h000] = 8'h34;
      fetch_op(16'h0FFF, 1);
      chk("wrap_op", 32'(opcode), 32'h1234);
      fetch_op(16'h1FFF, 0);

      // Random fetches, long enough to saturate the counter
      for (int k = 0; k < 20; k++) begin
         fetch_op(16'($urandom), int'($urandom_range(0, 3)));
      end
      chk("sat_cnt", 32'(fetch_cnt), CMAX);

      // Async reset mid-S_CAP
      set_pc(16'h0600);
      run = 1'b1;
      tick();
      run = 1'b0;
      tick();
      #1;
      rst = 1'b0;
      #1;
      chk("ar_valid", 32'(op_valid), 0);
      chk("ar_opcode", 32'(opcode), 0);
      chk("ar_cnt", 32'(fetch_cnt), 0);
      exp_cnt = 0;
      tick();
      rst = 1'b1;
      n0 = rd_cnt;
      for (int i = 0; i < 4; i++) tick();
      chk("ar_idle_rd", rd_cnt - n0, 0);
      chk("ar_idle_valid", 32'(op_valid), 0);
      fetch_op(16'h0200, 0);
      chk("ar_refetch", 32'(opcode), 32'h6A42);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
